// File: rtl/axis_vga_out.sv
// AXI-stream to VGA raster converter: free-running raster timing with the stream
// locked to it on tuser. Underflow and framing errors drop back to SEEK and re-lock.
module axis_vga_out #(
    parameter int WIDTH  = 24,
    parameter int HVALID = 640,
    parameter int HFP    = 16,
    parameter int HSYNC  = 96,
    parameter int HBP    = 48,
    parameter int VVALID = 480,
    parameter int VFP    = 10,
    parameter int VSYNC  = 2,
    parameter int VBP    = 33
) (
    input  logic             axis_clk,
    input  logic             rst,
    input  logic             in_axis_tvalid,
    output logic             in_axis_tready,
    input  logic             in_axis_tuser,
    input  logic             in_axis_tlast,
    input  logic [WIDTH-1:0] in_axis_tdata,
    output logic             vga_hsync_o,
    output logic             vga_vsync_o,
    output logic             vga_de_o,
    output logic [23:0]      vga_rgb_o,
    output logic             frame_start_o,
    output logic             locked_o,
    output logic [7:0]       underflow_cnt_o,
    output logic [7:0]       syncerr_cnt_o
);

    localparam int HTOTAL = HVALID + HFP + HSYNC + HBP;
    localparam int VTOTAL = VVALID + VFP + VSYNC + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(HVALID);
    localparam logic [HW-1:0] H_LAST_PIX = HW'(HVALID - 1);
    localparam logic [HW-1:0] H_SYNC_S   = HW'(HVALID + HFP);
    localparam logic [HW-1:0] H_SYNC_E   = HW'(HVALID + HFP + HSYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(VVALID);
    localparam logic [VW-1:0] V_SYNC_S   = VW'(VVALID + VFP);
    localparam logic [VW-1:0] V_SYNC_E   = VW'(VVALID + VFP + VSYNC);

    typedef enum logic [1:0] {SEEK, ARMED, LOCKED} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [HW-1:0]   r_h;
    logic [VW-1:0]   r_v;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_de;
    logic [23:0]     r_rgb;
    logic            r_frame_start;
    logic [7:0]      r_uf_cnt;
    logic [7:0]      r_se_cnt;

    logic            w_active;
    logic            w_origin;
    logic            w_frame_end;
    logic            w_uf_evt;
    logic            w_se_evt;
    logic            w_show;

    assign w_active    = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_origin    = (r_h == '0) && (r_v == '0);
    assign w_frame_end = (r_h == H_LAST) && (r_v == V_LAST);

    always_ff @(posedge axis_clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // A tuser beat away from the origin is left unconsumed so SEEK can arm on it.
    always_comb begin
        w_state_next   = r_state;
        in_axis_tready = 1'b0;
        w_uf_evt       = 1'b0;
        w_se_evt       = 1'b0;
        w_show         = 1'b0;
        case (r_state)
            SEEK: begin
                in_axis_tready = !(in_axis_tvalid && in_axis_tuser);
                if (in_axis_tvalid && in_axis_tuser) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                if (w_frame_end) begin
                    w_state_next = LOCKED;
                end
            end
            LOCKED: begin
                in_axis_tready = w_active && !(in_axis_tuser && !w_origin);
                if (w_active) begin
                    if (!in_axis_tvalid) begin
                        w_uf_evt     = 1'b1;
                        w_state_next = SEEK;
                    end else if (in_axis_tuser && !w_origin) begin
                        w_se_evt     = 1'b1;
                        w_state_next = SEEK;
                    end else begin
                        w_show = 1'b1;
                        if ((w_origin && !in_axis_tuser) ||
                            (in_axis_tlast != (r_h == H_LAST_PIX))) begin
                            w_se_evt     = 1'b1;
                            w_state_next = SEEK;
                        end
                    end
                end
            end
            default: w_state_next = SEEK;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (rst) begin
            r_state       <= SEEK;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_de          <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
            r_uf_cnt      <= '0;
            r_se_cnt      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_hsync       <= !((r_h >= H_SYNC_S) && (r_h < H_SYNC_E));
            r_vsync       <= !((r_v >= V_SYNC_S) && (r_v < V_SYNC_E));
            r_de          <= w_active;
            r_rgb         <= w_show ? in_axis_tdata[23:0] : 24'd0;
            r_frame_start <= w_origin;
            if (w_uf_evt && (r_uf_cnt != 8'hFF)) begin
                r_uf_cnt <= r_uf_cnt + 8'd1;
            end
            if (w_se_evt && (r_se_cnt != 8'hFF)) begin
                r_se_cnt <= r_se_cnt + 8'd1;
            end
        end
    end

    assign vga_hsync_o     = r_hsync;
    assign vga_vsync_o     = r_vsync;
    assign vga_de_o        = r_de;
    assign vga_rgb_o       = r_rgb;
    assign frame_start_o   = r_frame_start;
    assign locked_o        = (r_state == LOCKED);
    assign underflow_cnt_o = r_uf_cnt;
    assign syncerr_cnt_o   = r_se_cnt;

endmodule
